cluster_clock_divider: RTL
==========================

// Module: cluster_clock_divider
// PURPOSE
//   Programmable integer clock divider feeding the cluster clock inverter stage.
//   Divides clk_i by N (N >= 2) and drives clk_o from a flop, so the output is glitch-free.
//   A ratio change takes effect only at an output period boundary.
//   A 4-phase valid/ack handshake carries the new ratio from the SoC control registers.
// PARAMETERS
//   DIV_WIDTH    8   width of the divide ratio
//   DIV_DEFAULT  2   ratio loaded at reset; legal range 2 .. 2**DIV_WIDTH-1
// PORTS
//   clk_i          in   1          source clock; single clock domain
//   rstn_i         in   1          asynchronous, active-low reset
//   test_mode_i    in   1          DFT bypass: 1 -> clk_o = clk_i; static during operation
//   cfg_valid_i    in   1          new ratio request; held high until cfg_ack_o is seen
//   cfg_div_i      in   DIV_WIDTH  requested ratio; stable while cfg_valid_i = 1
//   cfg_ack_o      out  1          ratio applied; 4-phase acknowledge
//   clk_en_i       in   1          only with CLK_DIV_GATE_EN (see CONFIGURATION)
//   clk_o          out  1          divided clock, goes to the clock inverter
// BEHAVIOUR
//   State: cnt_q (DIV_WIDTH), div_q (DIV_WIDTH), clk_q, fsm_q {RUN, ACK}.
//   Reset values:
//     cnt_q = DIV_DEFAULT-1, div_q = DIV_DEFAULT, clk_q = 0, fsm_q = RUN.
//     cfg_ack_o = 0; clk_o = 0 when test_mode_i = 0.
//   Counter:
//     wrap = (cnt_q == div_q-1).
//     cnt_d = wrap ? 0 : cnt_q+1.
//     clk_q <= (cnt_d < (div_q>>1)).
//     Result: high for floor(N/2) cycles, low for ceil(N/2) cycles.
//   Timing after reset release:
//     first clk_i rising edge -> cnt 0, clk_o rises.
//     Period = N clk_i cycles; duty cycle is 50% for even N.
//   Ratio change (FSM):
//     RUN: on an edge with wrap & cfg_valid_i:
//       div_q <= sat(cfg_div_i), cnt_q <= 0, clk_q <= 1, cfg_ack_o <= 1, go to ACK.
//       The new period starts on that edge.
//     ACK: cfg_ack_o stays 1 while cfg_valid_i = 1.
//       When cfg_valid_i = 0: cfg_ack_o <= 0, go to RUN.
//       Requests are ignored in ACK.
//   sat(): cfg_div_i of 0 or 1 is loaded as 2; no error is flagged.
//   cfg_valid_i rising mid-period: the request waits for the next wrap. Latency <= N_old cycles.
//   Same ratio re-requested: still handshaked and still restarts the period at the wrap.
//   Reset mid-operation: all state returns to reset values immediately.
//     clk_o drops asynchronously; any pending request is lost.
//   test_mode_i = 1: clk_o = clk_i through a clock mux.
//     Counter and FSM keep running; the handshake still works.
// CONFIGURATION
//   CLUSTER_CLK_DIV_GATE_EN defined:
//     adds the clk_en_i port.
//     At a wrap with clk_en_i = 0: clk_q is held at 0 and cnt_q is held at div_q-1.
//     When clk_en_i = 1 again: the next edge wraps and clk_o rises.
//     A ratio update is still accepted while gated.
//   Macro undefined:
//     no clk_en_i port; the divider always runs.
// STRUCTURE
//   Package cluster_clk_pkg:
//     typedef enum logic {RUN, ACK} clk_div_state_e;
//     localparam CLK_DIV_MIN = 2.
//   Sub-module: pulp_clock_mux2 for the test_mode_i bypass (clk_q vs clk_i).
//     No combinational logic on the clock path besides this mux.
// TESTING
//   1 Reset, DIV_DEFAULT = 2, 10 cycles -> clk_o toggles every clk_i edge (1 high, 1 low); cfg_ack_o = 0.
//   2 Request cfg_div_i = 5 mid-period -> ack at the next wrap; then clk_o is 2 high / 3 low; new period starts on the ack edge.
//   3 Request cfg_div_i = 0, then 1 -> each acked; divider runs at /2.
//   4 Hold cfg_valid_i = 1 for 20 cycles after ack -> exactly one load; cfg_ack_o stays 1 until valid drops, then returns 0.
//   5 Assert rstn_i low mid-period at /7 -> clk_o = 0 at once; after release, clk_o runs /2 from the first edge.
//   6 test_mode_i = 1 -> clk_o == clk_i; with CLUSTER_CLK_DIV_GATE_EN, clk_en_i = 0 for 3 periods -> clk_o stays low, then resumes with clk_o rising 1 edge after enable.

Source files
------------

// File: rtl/cluster_clk_pkg.sv
// ---------------------------------------------------------------------------
// cluster_clk_pkg
//   Shared types and constants for the cluster clock divider.
//   - clk_div_state_e : handshake FSM states (RUN = free running,
//                       ACK = new ratio applied, waiting for valid to drop)
//   - CLK_DIV_MIN     : smallest legal divide ratio; requests below this
//                       are silently raised to it
// ---------------------------------------------------------------------------
package cluster_clk_pkg;

  typedef enum logic {
    RUN = 1'b0,
    ACK = 1'b1
  } clk_div_state_e;

  localparam int unsigned CLK_DIV_MIN = 2;

endpackage : cluster_clk_pkg

// File: rtl/pulp_clock_mux2.sv
// ---------------------------------------------------------------------------
// pulp_clock_mux2
//   Two-input clock multiplexer. Kept as its own cell so the clock path
//   can be mapped onto a dedicated clock-mux primitive during implementation.
// Ports:
//   clk0_i    in  1  clock selected when clk_sel_i = 0
//   clk1_i    in  1  clock selected when clk_sel_i = 1
//   clk_sel_i in  1  select (expected to be static while clocks run)
//   clk_o     out 1  selected clock
// ---------------------------------------------------------------------------
module pulp_clock_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);

  assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule : pulp_clock_mux2

// File: rtl/cluster_clock_divider.sv
// ---------------------------------------------------------------------------
// cluster_clock_divider
//   Programmable integer divider for the cluster clock. clk_o is driven
//   from a flop (clk_q), so it is glitch-free; the only element between the
//   flop and clk_o is the DFT bypass mux. A new ratio is taken over a 4-phase
//   valid/ack handshake and is only applied on an output period boundary
//   (counter wrap), where the new period starts immediately.
//
//   Output shape for ratio N: high for floor(N/2) cycles, then low for
//   ceil(N/2) cycles.
//
// Parameters:
//   DIV_WIDTH    width of the divide ratio
//   DIV_DEFAULT  ratio after reset (2 .. 2**DIV_WIDTH-1)
//
// Ports:
//   clk_i        in   1          source clock
//   rstn_i       in   1          asynchronous active-low reset
//   test_mode_i  in   1          1 -> clk_o follows clk_i (DFT bypass)
//   cfg_valid_i  in   1          new ratio request (held until ack seen)
//   cfg_div_i    in   DIV_WIDTH  requested ratio (0 and 1 load as 2)
//   cfg_ack_o    out  1          4-phase acknowledge
//   clk_en_i     in   1          output enable, only present when the
//                                macro CLUSTER_CLK_DIV_GATE_EN is defined
//   clk_o        out  1          divided clock
//
// Build option:
//   CLUSTER_CLK_DIV_GATE_EN  adds clk_en_i. When low at a wrap, the output
//                            parks low and the counter parks on its last
//                            value; re-enabling wraps on the next edge.
// ---------------------------------------------------------------------------
module cluster_clock_divider
  import cluster_clk_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DIV_DEFAULT = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 test_mode_i,
  input  logic                 cfg_valid_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  output logic                 cfg_ack_o,
`ifdef CLUSTER_CLK_DIV_GATE_EN
  input  logic                 clk_en_i,
`endif
  output logic                 clk_o
);

  localparam logic [DIV_WIDTH-1:0] DIV_MIN_W = DIV_WIDTH'(CLK_DIV_MIN);
  localparam logic [DIV_WIDTH-1:0] DIV_RST   = DIV_WIDTH'(DIV_DEFAULT);
  localparam logic [DIV_WIDTH-1:0] CNT_RST   = DIV_WIDTH'(DIV_DEFAULT - 1);

  // State
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 clk_q, clk_d;
  clk_div_state_e       fsm_q, fsm_d;

  // Derived values
  logic                 wrap;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic [DIV_WIDTH-1:0] half_div;
  logic [DIV_WIDTH-1:0] div_sat;
  logic                 run_en;

`ifdef CLUSTER_CLK_DIV_GATE_EN
  assign run_en = clk_en_i;
`else
  assign run_en = 1'b1;
`endif

  // cnt_q == div_q-1 marks the last cycle of the current output period.
  assign wrap     = (cnt_q == (div_q - 1'b1));
  assign cnt_inc  = wrap ? '0 : (cnt_q + 1'b1);
  assign half_div = div_q >> 1;

  // Ratios below the minimum cannot produce a clock; clamp silently.
  assign div_sat  = (cfg_div_i < DIV_MIN_W) ? DIV_MIN_W : cfg_div_i;

  // -------------------------------------------------------------------------
  // Next-state logic: counter, output flop and handshake FSM
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    clk_d = clk_q;
    fsm_d = fsm_q;

    if (wrap && !run_en) begin
      // Parked at the period boundary: output low, counter frozen on the
      // wrap value so the first enabled edge starts a fresh period.
      cnt_d = cnt_q;
      clk_d = 1'b0;
    end else begin
      // clk_q is computed from the *next* count so the flop output lines up
      // with the counter value it represents.
      cnt_d = cnt_inc;
      clk_d = (cnt_inc < half_div);
    end

    case (fsm_q)
      RUN: begin
        if (wrap && cfg_valid_i) begin
          div_d = div_sat;
          fsm_d = ACK;
          if (run_en) begin
            // New period starts on this very edge.
            cnt_d = '0;
            clk_d = 1'b1;
          end else begin
            // Accept the ratio but stay parked until re-enabled.
            cnt_d = div_sat - 1'b1;
            clk_d = 1'b0;
          end
        end
      end
      ACK: begin
        // Further requests are ignored until valid drops.
        if (!cfg_valid_i) begin
          fsm_d = RUN;
        end
      end
      default: begin
        fsm_d = RUN;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= CNT_RST;
      div_q <= DIV_RST;
      clk_q <= 1'b0;
      fsm_q <= RUN;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      clk_q <= clk_d;
      fsm_q <= fsm_d;
    end
  end

  // Ack is high exactly while the FSM waits for valid to drop.
  assign cfg_ack_o = (fsm_q == ACK);

  // -------------------------------------------------------------------------
  // Output clock: flop output or bypass, nothing else on the path
  // -------------------------------------------------------------------------
  pulp_clock_mux2 i_clk_mux (
    .clk0_i    (clk_q),
    .clk1_i    (clk_i),
    .clk_sel_i (test_mode_i),
    .clk_o     (clk_o)
  );

endmodule : cluster_clock_divider
